// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the radix-2 restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_e;
  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring iteration (shift in a dividend bit, trial-subtract the divisor).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             inBit,
  output logic [WIDTH-1:0] nextRem,
  output logic             qBit
);
  logic [WIDTH:0] shifted;
  assign shifted = {rem, inBit};
  assign qBit = shifted >= {1'b0, divisor};
  assign nextRem = WIDTH'(qBit ? shifted - {1'b0, divisor} : shifted);
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU unit beside EXU, quotient to Lo and remainder to Hi; DIV_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wLoData,
  output logic             wlo,
  output logic [WIDTH-1:0] wHiData,
  output logic             whi,
  output logic             div_zero
);
  localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{&DIV_ZERO_QUOT}};
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvsr, aMag, bMag, nextRem;
  logic qBit, aNeg, bNeg, quotNeg, remNeg, earlyExit;
  assign aNeg = signed_i & dividend_i[WIDTH-1];
  assign bNeg = signed_i & divisor_i[WIDTH-1];
  assign aMag = aNeg ? -dividend_i : dividend_i;
  assign bMag = bNeg ? -divisor_i : divisor_i;
`ifdef DIV_EARLY_EXIT_EN
  assign earlyExit = aMag < bMag;
`else
  assign earlyExit = 1'b0;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign wlo = done;
  assign whi = done;
  // quot doubles as the dividend shift register: MSB feeds the step, quotient bits enter at the LSB
  div_step #(.WIDTH(WIDTH)) uStep (
    .rem(rem),
    .divisor(dvsr),
    .inBit(quot[WIDTH-1]),
    .nextRem(nextRem),
    .qBit(qBit)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quot <= '0;
      dvsr <= '0;
      quotNeg <= 1'b0;
      remNeg <= 1'b0;
      div_zero <= 1'b0;
      wLoData <= '0;
      wHiData <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          quot <= aMag;
          dvsr <= bMag;
          rem <= '0;
          cnt <= '0;
          quotNeg <= aNeg ^ bNeg;
          remNeg <= aNeg;
          div_zero <= bMag == '0;
          if (bMag == '0 || earlyExit) begin
            state <= DONE;
            wLoData <= bMag == '0 ? ZERO_QUOT : '0;
            wHiData <= dividend_i;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: if (cancel) begin
          state <= IDLE;
        end else begin
          rem <= nextRem;
          quot <= {quot[WIDTH-2:0], qBit};
          cnt <= cnt + 1'b1;
          state <= cnt == CNT_W'(WIDTH - 1) ? FIX : BUSY;
        end
        FIX: if (cancel) begin
          state <= IDLE;
        end else begin
          wLoData <= quotNeg ? -quot : quot;
          wHiData <= remNeg ? -rem : rem;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
